// File: rtl/uart_rx_pkg.sv
// uart_rx_pkg: shared constants and state encoding for the UART Rx bit timer.
package uart_rx_pkg;
  localparam int DIV_MIN_DEFAULT = 8;
  localparam int FRAME_8N1 = 10;
  typedef enum logic {IDLE, RUN} state_t;
endpackage

// File: rtl/uart_rx_majority3.sv
// uart_rx_majority3: remembers the two previous rx cycles and votes 2-of-3 with the live rx.
module uart_rx_majority3 (
  input  logic clk,
  input  logic reset_n,
  input  logic rx,
  output logic vote
);
  logic [1:0] sh;
  always_ff @(posedge clk) begin
    if (!reset_n) sh <= '0;
    else sh <= {sh[0], rx};
  end
  assign vote = (sh[1] & sh[0]) | (sh[1] & rx) | (sh[0] & rx);
endmodule

// File: rtl/uart_rx_bit_timer.sv
// uart_rx_bit_timer: mid-bit sampling strobe generator with frame tracking and start-bit check.
// Defining UART_RX_MAJORITY_EN replaces the single mid-bit sample with a 2-of-3 vote.
module uart_rx_bit_timer
  import uart_rx_pkg::*;
#(
  parameter int DIV_WIDTH = 16,
  parameter int IDX_WIDTH = 4,
  parameter int DIV_MIN   = DIV_MIN_DEFAULT
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [DIV_WIDTH-1:0] baud_div,
  input  logic [IDX_WIDTH-1:0] frame_bits,
  input  logic                 start_detected,
  input  logic                 rx,
  output logic                 sampling_strobe,
  output logic                 sample_bit,
  output logic [IDX_WIDTH-1:0] bit_index,
  output logic                 frame_done,
  output logic                 start_error,
  output logic                 busy
);
  state_t state, state_d;
  logic [DIV_WIDTH-1:0] div_q, cnt, div_in;
  logic [IDX_WIDTH-1:0] nbits_q, idx, nbits_in;
  logic tick, last, false_start, sampled, stop;
`ifdef UART_RX_MAJORITY_EN
  uart_rx_majority3 u_vote (.clk(clk), .reset_n(reset_n), .rx(rx), .vote(sampled));
`else
  assign sampled = rx;
`endif
  assign div_in   = (baud_div < DIV_WIDTH'(DIV_MIN)) ? DIV_WIDTH'(DIV_MIN) : baud_div;
  assign nbits_in = (frame_bits < IDX_WIDTH'(2)) ? IDX_WIDTH'(2) : frame_bits;
  always_comb begin
    tick        = (state == RUN) && (cnt == div_q - DIV_WIDTH'(1));
    last        = idx == nbits_q - IDX_WIDTH'(1);
    false_start = (idx == '0) && sampled;
    stop        = tick && (last || false_start);
    state_d     = state;
    if (state == IDLE) state_d = start_detected ? RUN : IDLE;
    else state_d = stop ? IDLE : RUN;
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state           <= IDLE;
      div_q           <= '0;
      nbits_q         <= '0;
      cnt             <= '0;
      idx             <= '0;
      sampling_strobe <= 1'b0;
      sample_bit      <= 1'b0;
      bit_index       <= '0;
      frame_done      <= 1'b0;
      start_error     <= 1'b0;
      busy            <= 1'b0;
    end else begin
      state           <= state_d;
      sampling_strobe <= tick;
      frame_done      <= tick && last;
      start_error     <= tick && false_start;
      if (tick) begin
        sample_bit <= sampled;
        bit_index  <= idx;
      end
      // Starting half a bit in places the first strobe at mid-start-bit.
      if (state == IDLE && start_detected) begin
        div_q   <= div_in;
        nbits_q <= nbits_in;
        cnt     <= div_in >> 1;
        idx     <= '0;
        busy    <= 1'b1;
      end else if (state == RUN) begin
        cnt <= tick ? '0 : cnt + 1'b1;
        if (tick) idx <= idx + 1'b1;
        if (stop) busy <= 1'b0;
      end
    end
  end
endmodule

// File: doc/uart_rx_bit_timer.md
Name: uart_rx_bit_timer

Overview:
- Parametrised successor to the UART Rx sampling strobe generator.
- Runtime-programmable clocks-per-bit and frame length.
- Tracks bit position across a whole frame and validates the start bit.
- Registers the sampled line value and flags frame completion.
- Sits between the Rx start-bit detector and the Rx shift register / frame assembler.

Parameters:
- DIV_WIDTH, 16, width of baud_div; max clocks-per-bit is 2**DIV_WIDTH-1.
- IDX_WIDTH, 4, width of frame_bits and bit_index; max frame is 2**IDX_WIDTH-1 bits.
- DIV_MIN, 8, smallest accepted clocks-per-bit; smaller programmed values are treated as DIV_MIN.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  reset, synchronous, active-low; one clock domain (clk).
- baud_div  in  DIV_WIDTH  clocks per UART bit; latched only when a frame starts.
- frame_bits  in  IDX_WIDTH  bits per frame including start and stop (8N1 = 10); legal 2..max; latched at frame start.
- start_detected  in  1  single-cycle pulse from the start detector.
- rx  in  1  serial line, already synchronised to clk.
- sampling_strobe  out  1  one-cycle pulse at mid-bit.
- sample_bit  out  1  sampled line value; valid while sampling_strobe=1.
- bit_index  out  IDX_WIDTH  index of the bit strobed; 0 = start bit; valid with the strobe.
- frame_done  out  1  pulse coincident with the strobe of the last bit.
- start_error  out  1  pulse coincident with the bit-0 strobe when that sample is 1 (false start).
- busy  out  1  high while a frame is being timed.

Behaviour:
- Reset (reset_n=0 at a clk edge):
  - State goes to IDLE; counter, index and all outputs go to 0.
  - Reset has priority over start_detected and is honoured mid-frame.
- States:
  - IDLE: start_detected=1 → RUN. On that edge, latch div_q = max(baud_div, DIV_MIN) and nbits_q = frame_bits, load counter = div_q>>1, clear index, set busy=1.
  - RUN: counter increments by 1 per cycle. When counter == div_q-1, the next edge sets counter=0 and sampling_strobe=1 with bit_index = current index, then index increments.
- Strobe timing:
  - First strobe is high in the cycle after the (div_q - (div_q>>1))th edge following the capture edge: div 8 → 4th edge, div 9 → 5th edge.
  - Subsequent strobes occur every div_q cycles.
  - Strobes are always single-cycle; two adjacent strobe cycles never occur.
- Last bit: on the edge that strobes bit_index == nbits_q-1, assert frame_done, set busy=0 and return to IDLE. Returning at mid-stop-bit lets the next start edge be caught.
- False start: the bit-0 strobe with sample_bit=1 asserts start_error, asserts no frame_done, sets busy=0 and returns to IDLE.
- Start during a frame: start_detected while in RUN is ignored; no resync.
  - start_detected in the cycle after busy falls is accepted.
- Programming changes: changes to baud_div or frame_bits during RUN have no effect until the next frame.
- Invariants: counter < div_q at all times. frame_bits < 2 is treated as 2.

Optional Feature:
- Macro: UART_RX_MAJORITY_EN.
- Defined: rx is captured in the three cycles where counter equals div_q-3, div_q-2 and div_q-1. sample_bit is the 2-of-3 majority, registered on the strobe edge.
- Undefined: sample_bit = rx captured when counter == div_q-1, registered on the strobe edge.
- Strobe timing is identical either way; DIV_MIN ≥ 6 guarantees all three samples fall inside bit 0.

Decomposition:
- Package uart_rx_pkg: DIV_MIN_DEFAULT, state encoding (IDLE, RUN) and the 8N1 frame constant (10).
- Sub-module uart_rx_majority3: 3-sample shift register and vote. Instantiated only under UART_RX_MAJORITY_EN.

Test Plan:
- 8N1 frame:
  - Stimulus: baud_div=8, frame_bits=10; start_detected at edge 0; rx low for the start bit, data 0x55 LSB first, stop bit 1.
  - Response: strobes at edges 4, 12, …, 76. bit_index runs 0..9; sample_bits 0,1,0,1,0,1,0,1,0,1. frame_done with strobe 9; busy low from edge 76.
- False start:
  - Stimulus: rx returns high before mid-start.
  - Response: strobe 0 with sample_bit=1, start_error=1, no frame_done, busy=0; a new start_detected 1 cycle later is accepted.
- Clamp and odd divisor:
  - baud_div=3 → behaves as 8: first strobe at edge 4.
  - baud_div=9 → first strobe at edge 5, then a period of 9.
- Retrigger and programming:
  - Stimulus: start_detected pulsed at bit 3; baud_div changed to 16 mid-frame.
  - Response: strobe spacing stays 8 and indices continue; the next frame uses 16.
- Reset mid-frame: reset_n=0 for 1 cycle at bit 5 → all outputs 0 next cycle; no strobe until a new start_detected.
- With UART_RX_MAJORITY_EN:
  - A 1-cycle glitch to 1 at counter=div-2 during a 0 bit → sample_bit=0.
  - Two glitched cycles → sample_bit=1.
